sobel_magnitude_threshold: RTL and testbench

//  Consumes the 3x3 window stream and edge flags of the upstream 3x3 matrix generator (8-bit gray).

---
 rtl/sobel_magnitude_threshold_pkg.sv | 16 +
 rtl/sobel_magnitude_threshold_border_mux.sv | 29 ++
 rtl/sobel_magnitude_threshold.sv | 88 ++++++++
 tb/tb_sobel_magnitude_threshold.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/sobel_magnitude_threshold_pkg.sv
// sobel_magnitude_threshold_pkg: shared pixel/magnitude widths, Sobel kernel weights and 8-bit saturation
package sobel_magnitude_threshold_pkg;
   localparam int PIX_W  = 8;
   localparam int SUM_W  = 10;
   localparam int MAG_W  = 11;
   localparam int K_EDGE = 1;
   localparam int K_MID  = 2;
   typedef logic [PIX_W-1:0] pix_t;
   typedef pix_t [0:2][0:2] win_t;
   function automatic logic [SUM_W-1:0] ksum(input pix_t a, input pix_t b, input pix_t c);
      return SUM_W'(K_EDGE) * SUM_W'(a) + SUM_W'(K_MID) * SUM_W'(b) + SUM_W'(K_EDGE) * SUM_W'(c);
   endfunction
   function automatic pix_t sat8(input logic [MAG_W-1:0] v);
      return (v > MAG_W'(255)) ? pix_t'(255) : v[PIX_W-1:0];
   endfunction
endpackage

// File: rtl/sobel_magnitude_threshold_border_mux.sv
// sobel_border_mux: registered 3x3 window with border replication (rows first, then columns)
module sobel_border_mux
   import sobel_magnitude_threshold_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  win_t win_i,
   input  logic top_i,
   input  logic bottom_i,
   input  logic left_i,
   input  logic right_i,
   output win_t win_o
);
   win_t rows_sub, win_d, win_q;
   always_comb begin
      rows_sub    = win_i;
      rows_sub[0] = top_i ? win_i[1] : win_i[0];
      rows_sub[2] = bottom_i ? win_i[1] : win_i[2];
      win_d       = rows_sub;
      for (int r = 0; r < 3; r++) begin
         win_d[r][0] = left_i ? rows_sub[r][1] : rows_sub[r][0];
         win_d[r][2] = right_i ? rows_sub[r][1] : rows_sub[r][2];
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) win_q <= '0;
      else win_q <= win_d;
   assign win_o = win_q;
endmodule

// File: rtl/sobel_magnitude_threshold.sv
// sobel_magnitude_threshold: 4-stage Sobel |Gx|+|Gy| edge magnitude with saturated gray and per-frame threshold bit
module sobel_magnitude_threshold
   import sobel_magnitude_threshold_pkg::*;
#(
   parameter logic [1:0]       MAG_SHIFT = 2'd0,
   parameter logic [MAG_W-1:0] THR_RESET = 11'd128
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             matrix_img_vsync,
   input  logic             matrix_img_href,
   input  logic             matrix_top_edge_flag,
   input  logic             matrix_bottom_edge_flag,
   input  logic             matrix_left_edge_flag,
   input  logic             matrix_right_edge_flag,
   input  logic [PIX_W-1:0] matrix_p11,
   input  logic [PIX_W-1:0] matrix_p12,
   input  logic [PIX_W-1:0] matrix_p13,
   input  logic [PIX_W-1:0] matrix_p21,
   input  logic [PIX_W-1:0] matrix_p22,
   input  logic [PIX_W-1:0] matrix_p23,
   input  logic [PIX_W-1:0] matrix_p31,
   input  logic [PIX_W-1:0] matrix_p32,
   input  logic [PIX_W-1:0] matrix_p33,
   input  logic [MAG_W-1:0] cfg_threshold,
   output logic             post_img_vsync,
   output logic             post_img_href,
   output logic [PIX_W-1:0] post_img_gray,
   output logic             post_img_bit
);
   win_t                    win_in, win_s1;
   logic [SUM_W-1:0]        r_d, l_d, b_d, t_d, r_q, l_q, b_q, t_q;
   logic signed [MAG_W-1:0] gx, gy;
   logic [MAG_W-1:0]        mag_d, mag_q, thr_use, thr_q, pend_q;
   logic [3:0]              href_q, vs_q;
   logic [PIX_W-1:0]        gray_d, gray_q;
   logic                    bit_d, bit_q;
   assign win_in = {matrix_p11, matrix_p12, matrix_p13,
                    matrix_p21, matrix_p22, matrix_p23,
                    matrix_p31, matrix_p32, matrix_p33};
   sobel_border_mux u_border_mux (
      .clk      (clk),
      .rst_n    (rst_n),
      .win_i    (win_in),
      .top_i    (matrix_top_edge_flag),
      .bottom_i (matrix_bottom_edge_flag),
      .left_i   (matrix_left_edge_flag),
      .right_i  (matrix_right_edge_flag),
      .win_o    (win_s1)
   );
   // a new frame's threshold is swapped in exactly when its first window reaches the compare stage
   always_comb begin
      r_d     = ksum(win_s1[0][2], win_s1[1][2], win_s1[2][2]);
      l_d     = ksum(win_s1[0][0], win_s1[1][0], win_s1[2][0]);
      b_d     = ksum(win_s1[2][0], win_s1[2][1], win_s1[2][2]);
      t_d     = ksum(win_s1[0][0], win_s1[0][1], win_s1[0][2]);
      gx      = $signed({1'b0, r_q}) - $signed({1'b0, l_q});
      gy      = $signed({1'b0, b_q}) - $signed({1'b0, t_q});
      mag_d   = (gx[MAG_W-1] ? MAG_W'(-gx) : MAG_W'(gx)) + (gy[MAG_W-1] ? MAG_W'(-gy) : MAG_W'(gy));
      thr_use = (vs_q[2] && !vs_q[3]) ? pend_q : thr_q;
      gray_d  = href_q[2] ? sat8(mag_q >> MAG_SHIFT) : '0;
      bit_d   = href_q[2] && (mag_q > thr_use);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         {r_q, l_q, b_q, t_q} <= '0;
         mag_q                <= '0;
         gray_q               <= '0;
         bit_q                <= 1'b0;
         thr_q                <= THR_RESET;
         pend_q               <= THR_RESET;
         href_q               <= '0;
         vs_q                 <= '0;
      end else begin
         {r_q, l_q, b_q, t_q} <= {r_d, l_d, b_d, t_d};
         mag_q                <= mag_d;
         gray_q               <= gray_d;
         bit_q                <= bit_d;
         thr_q                <= thr_use;
         if (matrix_img_vsync && !vs_q[0]) pend_q <= cfg_threshold;
         href_q               <= {href_q[2:0], matrix_img_href};
         vs_q                 <= {vs_q[2:0], matrix_img_vsync};
      end
   assign post_img_vsync = vs_q[3];
   assign post_img_href  = href_q[3];
   assign post_img_gray  = gray_q;
   assign post_img_bit   = bit_q;
endmodule

// File: tb/tb_sobel_magnitude_threshold.sv
// tb_sobel_magnitude_threshold: random and directed frames against an image-level Sobel model, two MAG_SHIFT builds
module tb_sobel_magnitude_threshold;
   typedef struct packed { logic vs; logic hs; logic [10:0] mag; logic b; } exp_t;
   logic        clk = 1'b0, rst_n = 1'b1;
   logic        vs_i = 1'b0, hs_i = 1'b0, top_f = 1'b0, bot_f = 1'b0, lft_f = 1'b0, rgt_f = 1'b0;
   logic [7:0]  win [3][3];
   logic [10:0] cfg = 11'd128;
   logic        vs0, hs0, bit0, vs2, hs2, bit2;
   logic [7:0]  gray0, gray2;
   int          img [16][16];
   int          H = 1, W = 1;
   int          m_thr = 128;
   logic        prev_vs = 1'b0;
   exp_t        cur = '0;
   exp_t        pipe [4];
   int          checks = 0, failures = 0;

   always #5 clk = ~clk;

   sobel_magnitude_threshold #(.MAG_SHIFT(2'd0), .THR_RESET(11'd128)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .matrix_img_vsync(vs_i), .matrix_img_href(hs_i),
      .matrix_top_edge_flag(top_f), .matrix_bottom_edge_flag(bot_f),
      .matrix_left_edge_flag(lft_f), .matrix_right_edge_flag(rgt_f),
      .matrix_p11(win[0][0]), .matrix_p12(win[0][1]), .matrix_p13(win[0][2]),
      .matrix_p21(win[1][0]), .matrix_p22(win[1][1]), .matrix_p23(win[1][2]),
      .matrix_p31(win[2][0]), .matrix_p32(win[2][1]), .matrix_p33(win[2][2]),
      .cfg_threshold(cfg), .post_img_vsync(vs0), .post_img_href(hs0),
      .post_img_gray(gray0), .post_img_bit(bit0));

   sobel_magnitude_threshold #(.MAG_SHIFT(2'd2), .THR_RESET(11'd128)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .matrix_img_vsync(vs_i), .matrix_img_href(hs_i),
      .matrix_top_edge_flag(top_f), .matrix_bottom_edge_flag(bot_f),
      .matrix_left_edge_flag(lft_f), .matrix_right_edge_flag(rgt_f),
      .matrix_p11(win[0][0]), .matrix_p12(win[0][1]), .matrix_p13(win[0][2]),
      .matrix_p21(win[1][0]), .matrix_p22(win[1][1]), .matrix_p23(win[1][2]),
      .matrix_p31(win[2][0]), .matrix_p32(win[2][1]), .matrix_p33(win[2][2]),
      .cfg_threshold(cfg), .post_img_vsync(vs2), .post_img_href(hs2),
      .post_img_gray(gray2), .post_img_bit(bit2));

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int px(input int r, input int c);
      return img[r < 0 ? 0 : (r >= H ? H - 1 : r)][c < 0 ? 0 : (c >= W ? W - 1 : c)];
   endfunction

   function automatic int mag_at(input int r, input int c);
      int gx, gy;
      gx = px(r-1, c+1) + 2*px(r, c+1) + px(r+1, c+1) - px(r-1, c-1) - 2*px(r, c-1) - px(r+1, c-1);
      gy = px(r+1, c-1) + 2*px(r+1, c) + px(r+1, c+1) - px(r-1, c-1) - 2*px(r-1, c) - px(r-1, c+1);
      return (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
   endfunction

   // kind: 0 flat, 1 vertical step at col 2, 2 single 255 dot at (2,2), 3 random 0..maxv
   function automatic void fill(input int h, input int w, input int kind, input int maxv);
      H = h;
      W = w;
      for (int r = 0; r < h; r++)
         for (int c = 0; c < w; c++)
            img[r][c] = kind == 0 ? maxv : kind == 1 ? (c >= 2 ? 200 : 0) :
                        kind == 2 ? ((r == 2 && c == 2) ? 255 : 0) : int'($urandom_range(0, maxv));
   endfunction

   // spec latency: whatever enters at an edge is visible on the outputs four edges later
   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= cur;
         for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
      end

   always @(negedge clk) begin
      check("vsync_s0", int'(vs0), int'(pipe[3].vs));
      check("href_s0", int'(hs0), int'(pipe[3].hs));
      check("gray_s0", int'(gray0), pipe[3].hs ? (pipe[3].mag > 255 ? 255 : int'(pipe[3].mag)) : 0);
      check("bit_s0", int'(bit0), int'(pipe[3].b));
      check("vsync_s2", int'(vs2), int'(pipe[3].vs));
      check("href_s2", int'(hs2), int'(pipe[3].hs));
      check("gray_s2", int'(gray2), pipe[3].hs ? ((pipe[3].mag >> 2) > 255 ? 255 : int'(pipe[3].mag >> 2)) : 0);
      check("bit_s2", int'(bit2), int'(pipe[3].b));
   end

   task automatic cyc(input logic vs, input logic hs, input int r, input int c);
      int m, rr, cc;
      @(posedge clk);
      #1;
      if (vs && !prev_vs) m_thr = int'(cfg);
      prev_vs = vs;
      vs_i  = vs;
      hs_i  = hs;
      top_f = hs ? (r == 0) : 1'($urandom);
      bot_f = hs ? (r == H - 1) : 1'($urandom);
      lft_f = hs ? (c == 0) : 1'($urandom);
      rgt_f = hs ? (c == W - 1) : 1'($urandom);
      for (int dr = 0; dr < 3; dr++)
         for (int dc = 0; dc < 3; dc++) begin
            rr = r + dr - 1;
            cc = c + dc - 1;
            win[dr][dc] = (hs && rr >= 0 && rr < H && cc >= 0 && cc < W) ? 8'(img[rr][cc]) : 8'($urandom);
         end
      m = hs ? mag_at(r, c) : 0;
      cur.vs  = vs;
      cur.hs  = hs;
      cur.mag = 11'(m);
      cur.b   = hs && (m > m_thr);
   endtask

   // vs_len: -1 no vsync, 0 vsync coincident with first pixel, >0 vsync pulse length before the frame
   task automatic frame(input int vs_len, input int pre, input int hbl, input int post, input int cfg_mid);
      for (int i = 0; i < vs_len; i++) cyc(1'b1, 1'b0, 0, 0);
      for (int i = 0; i < pre; i++) cyc(1'b0, 1'b0, 0, 0);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            if (cfg_mid >= 0 && r == H / 2 && c == 0) cfg = 11'(cfg_mid);
            cyc(vs_len == 0 && r == 0 && c == 0, 1'b1, r, c);
            if (c == W - 1) for (int i = 0; i < hbl; i++) cyc(1'b0, 1'b0, 0, 0);
         end
      for (int i = 0; i < post; i++) cyc(1'b0, 1'b0, 0, 0);
   endtask

   task automatic do_reset(input int n);
      #2 rst_n = 1'b0;
      vs_i    = 1'b0;
      hs_i    = 1'b0;
      cur     = '0;
      prev_vs = 1'b0;
      m_thr   = 128;
      repeat (n) @(posedge clk);
      #3 rst_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++) win[i][j] = 8'd0;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      fill(4, 4, 0, 100);
      check("pin_flat_mid", mag_at(1, 1), 0);
      check("pin_flat_corner", mag_at(0, 0), 0);
      frame(2, 4, 2, 5, -1);
      cfg = 11'd100;
      fill(4, 4, 1, 0);
      check("pin_step_c1", mag_at(0, 1), 800);
      check("pin_step_c2", mag_at(3, 2), 800);
      check("pin_step_c0", mag_at(1, 0), 0);
      check("pin_step_c3", mag_at(2, 3), 0);
      frame(2, 4, 0, 5, 700);
      check("pin_thr_kept", m_thr, 100);
      fill(5, 5, 2, 0);
      check("pin_dot_edge", mag_at(1, 2), 510);
      check("pin_dot_corner", mag_at(1, 1), 510);
      check("pin_dot_centre", mag_at(2, 2), 0);
      frame(1, 3, 1, 5, -1);
      check("pin_thr_next", m_thr, 700);
      fill(4, 4, 1, 0);
      frame(0, 0, 0, 0, -1);
      fill(1, 6, 3, 255);
      frame(0, 0, 0, 0, -1);
      fill(5, 1, 3, 255);
      frame(1, 0, 1, 2, -1);
      for (int f = 0; f < 10; f++) begin
         cfg = 11'($urandom_range(0, 900));
         fill(int'($urandom_range(1, 12)), int'($urandom_range(1, 12)), 3, f[0] ? 255 : 63);
         frame(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
               int'($urandom_range(0, 2)), f == 4 ? int'($urandom_range(0, 900)) : -1);
      end
      cfg = 11'd600;
      fill(6, 6, 3, 255);
      cyc(1'b1, 1'b0, 0, 0);
      for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, i / 6, i % 6);
      do_reset(2);
      fill(6, 6, 3, 63);
      frame(-1, 1, 1, 4, -1);
      check("pin_thr_reset", m_thr, 128);
      cfg = 11'd300;
      fill(6, 6, 3, 255);
      frame(2, 2, 0, 6, -1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
